// File: rtl/stk_alu_pkg.sv
// Shared definitions for the stack-machine ALU sequencer: opcodes, FSM states, flag indices.
package stk_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StPop1,
        StRcv1,
        StPop2,
        StRcv2,
        StExec,
        StPush,
        StRestore,
        StDoneErr
    } state_e;

    // Bit positions inside the packed {z,s,c,v} flag vector.
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic op_writes_result(logic [2:0] op);
        return op != OP_CMP;
    endfunction

endpackage

// File: rtl/stk_alu_core.sv
// Combinational ALU datapath: result and {z,s,c,v} flags for one opcode.
module stk_alu_core
    import stk_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned MSB  = DATA_W - 1;

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] res;
    logic [SH_W-1:0]   sh;
    logic              carry;
    logic              ovf;

    always_comb begin
        wide  = '0;
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        sh    = b_i[SH_W-1:0];
        case (op_i)
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                ovf   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // Top bit of the widened difference is the borrow (a < b unsigned).
                wide  = {1'b0, a_i} - {1'b0, b_i};
                res   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
                ovf   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_SHL: begin
                wide  = {1'b0, a_i} << sh;
                res   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_SRA: begin
                // A guard bit below the LSB catches the last bit shifted out.
                wide  = $signed({a_i, 1'b0}) >>> sh;
                res   = wide[DATA_W:1];
                carry = wide[0];
            end
            default: ;
        endcase
        result_o        = res;
        flags_o         = '0;
        flags_o[FLAG_Z] = ~|res;
        flags_o[FLAG_S] = res[MSB];
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

endmodule

// File: rtl/stk_alu_seq.sv
// Stack ALU sequencer: pops two operands, executes one opcode, pushes the result, updates flags.
module stk_alu_seq
    import stk_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [2:0]        op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              z_flag,
    output logic              s_flag,
    output logic              c_flag,
    output logic              v_flag,
    output logic              stk_pop,
    input  logic [DATA_W-1:0] stk_rd_data,
    output logic              stk_push,
    output logic [DATA_W-1:0] stk_wr_data,
    input  logic              stk_empty,
    input  logic              stk_full
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;

    logic [DATA_W-1:0] core_res;
    logic [3:0]        core_flags;

    stk_alu_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .result_o(core_res),
        .flags_o (core_flags)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        flags_d     = flags_q;
        busy        = state_q != StIdle;
        done        = 1'b0;
        err         = 1'b0;
        stk_pop     = 1'b0;
        stk_push    = 1'b0;
        stk_wr_data = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    state_d = StPop1;
                end
            end
            StPop1: begin
                if (stk_empty) begin
                    state_d = StDoneErr;
                end else begin
                    stk_pop = 1'b1;
                    state_d = StRcv1;
                end
            end
            StRcv1: begin
                a_d     = stk_rd_data;
                state_d = StPop2;
            end
            StPop2: begin
                // a has already left the stack; put it back before reporting the error.
                if (stk_empty) begin
                    state_d = StRestore;
                end else begin
                    stk_pop = 1'b1;
                    state_d = StRcv2;
                end
            end
            StRcv2: begin
                b_d     = stk_rd_data;
                state_d = StExec;
            end
            StExec: begin
                res_d   = core_res;
                flags_d = core_flags;
                state_d = StPush;
            end
            StPush: begin
                done    = 1'b1;
                state_d = StIdle;
                if (op_writes_result(op_q)) begin
                    if (stk_full) begin
                        err = 1'b1;
                    end else begin
                        stk_push    = 1'b1;
                        stk_wr_data = res_q;
                    end
                end
            end
            StRestore: begin
                stk_push    = 1'b1;
                stk_wr_data = a_q;
                state_d     = StDoneErr;
            end
            StDoneErr: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign z_flag = flags_q[FLAG_Z];
    assign s_flag = flags_q[FLAG_S];
    assign c_flag = flags_q[FLAG_C];
    assign v_flag = flags_q[FLAG_V];

endmodule

// File: tb/tb_stk_alu_seq.sv
// Randomised bench for stk_alu_seq with a behavioural LIFO and a transaction-level reference model.
module tb_stk_alu_seq;

    localparam int unsigned DW    = 8;
    localparam int unsigned STK_D = 8;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [2:0]    op;
    logic          busy;
    logic          done;
    logic          err;
    logic          z_flag;
    logic          s_flag;
    logic          c_flag;
    logic          v_flag;
    logic          stk_pop;
    logic [DW-1:0] stk_rd_data;
    logic          stk_push;
    logic [DW-1:0] stk_wr_data;
    logic          stk_empty;
    logic          stk_full;

    logic [DW-1:0] stk[$];
    logic          force_full;
    logic [3:0]    exp_fl;
    logic [DW-1:0] last_wval;
    int            n_checks;
    int            n_pass;

    logic          smp_pop;
    logic          smp_push;
    logic          smp_done;
    logic          smp_err;
    logic          smp_busy;
    logic [DW-1:0] smp_wval;

    stk_alu_seq #(
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .z_flag     (z_flag),
        .s_flag     (s_flag),
        .c_flag     (c_flag),
        .v_flag     (v_flag),
        .stk_pop    (stk_pop),
        .stk_rd_data(stk_rd_data),
        .stk_push   (stk_push),
        .stk_wr_data(stk_wr_data),
        .stk_empty  (stk_empty),
        .stk_full   (stk_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic upd_pins();
        stk_empty = stk.size() == 0;
        stk_full  = force_full || (stk.size() >= STK_D);
    endtask

    // Sample DUT at negedge, then model the stack's reaction to the strobes after the posedge.
    task automatic tick();
        @(negedge clk);
        smp_pop  = stk_pop;
        smp_push = stk_push;
        smp_wval = stk_wr_data;
        smp_done = done;
        smp_err  = err;
        smp_busy = busy;
        @(posedge clk);
        #1;
        if (smp_pop && stk.size() > 0) stk_rd_data = stk.pop_back();
        if (smp_push) stk.push_back(smp_wval);
        upd_pins();
    endtask

    function automatic logic [DW-1:0] pick();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 7))
            0: t = 32'h00;
            1: t = 32'h7F;
            2: t = 32'h80;
            3: t = 32'hFF;
            4: t = 32'h01;
            default: ;
        endcase
        return t[DW-1:0];
    endfunction

    task automatic load(input int n, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        stk.delete();
        if (n >= 2) stk.push_back(lo);
        if (n >= 1) stk.push_back(hi);
        upd_pins();
    endtask

    task automatic load_rand(input int n);
        stk.delete();
        repeat (n) stk.push_back(pick());
        upd_pins();
    endtask

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int opc, input int a, input int b,
                                    output int res, output logic [3:0] fl);
        int   m;
        int   half;
        int   sa;
        int   sb;
        int   sr;
        int   r;
        int   sh;
        logic c;
        logic v;
        m    = (1 << DW) - 1;
        half = 1 << (DW - 1);
        sa   = (a >= half) ? a - (1 << DW) : a;
        sb   = (b >= half) ? b - (1 << DW) : b;
        sh   = b % DW;
        r    = 0;
        sr   = 0;
        c    = 1'b0;
        v    = 1'b0;
        case (opc)
            0: begin
                r  = a + b;
                c  = r > m;
                sr = sa + sb;
                v  = (sr >= half) || (sr < -half);
            end
            1, 7: begin
                r  = a - b;
                c  = a < b;
                sr = sa - sb;
                v  = (sr >= half) || (sr < -half);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = a << sh;
                c = (sh != 0) && (((a >> (DW - sh)) & 1) == 1);
            end
            6: begin
                r = sa >>> sh;
                c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1);
            end
            default: ;
        endcase
        res = r & m;
        fl  = {res == 0, (res & half) != 0, c, v};
    endfunction

    task automatic run_op(input logic [2:0] op_v, input bit poke);
        logic [DW-1:0] exp_stk[$];
        int            depth;
        int            a;
        int            b;
        int            r;
        int            e_done;
        int            d_cyc;
        int            n_done;
        logic          e_err;
        logic          g_err;
        logic          busy1;
        logic [9:0]    e_pm;
        logic [9:0]    e_wm;
        logic [9:0]    pm;
        logic [9:0]    wm;
        logic [DW-1:0] e_wv;
        logic [3:0]    fl;

        exp_stk = stk;
        depth   = exp_stk.size();
        e_pm    = '0;
        e_wm    = '0;
        e_wv    = '0;
        e_err   = 1'b0;
        e_done  = 6;
        r       = 0;
        if (depth == 0) begin
            e_done = 2;
            e_err  = 1'b1;
        end else if (depth == 1) begin
            e_done  = 5;
            e_err   = 1'b1;
            e_pm[1] = 1'b1;
            e_wm[4] = 1'b1;
            e_wv    = exp_stk[0];
        end else begin
            a = int'(exp_stk.pop_back());
            b = int'(exp_stk.pop_back());
            ref_alu(int'(op_v), a, b, r, fl);
            exp_fl  = fl;
            e_pm[1] = 1'b1;
            e_pm[3] = 1'b1;
            if (op_v != 3'b111) begin
                if (force_full) begin
                    e_err = 1'b1;
                end else begin
                    e_wm[6] = 1'b1;
                    e_wv    = r[DW-1:0];
                    exp_stk.push_back(r[DW-1:0]);
                end
            end
        end

        d_cyc     = -1;
        n_done    = 0;
        g_err     = 1'b0;
        busy1     = 1'b0;
        pm        = '0;
        wm        = '0;
        last_wval = '0;
        start     = 1'b1;
        op        = op_v;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (smp_done) begin
                n_done++;
                if (d_cyc < 0) begin
                    d_cyc = k;
                    g_err = smp_err;
                end
            end
            pm[k] = smp_pop;
            wm[k] = smp_push;
            if (smp_push) last_wval = smp_wval;
            if (k == 1) busy1 = smp_busy;
            // A second start during the op must be ignored; op is scrambled after acceptance.
            start = poke && (k == 0);
            op    = 3'($urandom);
        end
        start = 1'b0;

        check("done_cycle", d_cyc, e_done);
        check("done_count", n_done, 1);
        check("err", 32'(g_err), 32'(e_err));
        check("busy", 32'(busy1), 32'd1);
        check("idle_busy", 32'(smp_busy), 32'd0);
        check("pop_timing", 32'(pm), 32'(e_pm));
        check("push_timing", 32'(wm), 32'(e_wm));
        if (e_wm != 0) check("push_data", 32'(last_wval), 32'(e_wv));
        check("flags", 32'({z_flag, s_flag, c_flag, v_flag}), 32'(exp_fl));
        check("stk_depth", stk.size(), exp_stk.size());
        if (exp_stk.size() > 0 && stk.size() > 0)
            check("stk_top", 32'(stk[$]), 32'(exp_stk[$]));
    endtask

    task automatic reset_mid_op();
        int n_push;
        n_push = 0;
        load(2, 8'h09, 8'h07);
        start = 1'b1;
        op    = 3'b000;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        check("rst_async_out", 32'({busy, done, err, stk_pop, stk_push,
                                    z_flag, s_flag, c_flag, v_flag, stk_wr_data}), 32'd0);
        repeat (2) begin
            tick();
            if (smp_push) n_push++;
        end
        check("rst_no_push", n_push, 0);
        check("rst_depth", stk.size(), 0);
        rstn   = 1'b1;
        exp_fl = 4'b0000;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rstn        = 1'b0;
        start       = 1'b0;
        op          = 3'b000;
        stk_rd_data = '0;
        force_full  = 1'b0;
        exp_fl      = 4'b0000;
        last_wval   = '0;
        stk.delete();
        upd_pins();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'({busy, done, err, stk_pop, stk_push,
                                z_flag, s_flag, c_flag, v_flag, stk_wr_data}), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        load(2, 8'h05, 8'h03);
        run_op(3'b000, 1'b0);
        check("add_3_5", 32'(last_wval), 32'h08);
        load(2, 8'h05, 8'h03);
        run_op(3'b001, 1'b0);
        check("sub_val", 32'(last_wval), 32'hFE);
        check("sub_flags", 32'({z_flag, s_flag, c_flag, v_flag}), 32'b0110);
        load(2, 8'h01, 8'h7F);
        run_op(3'b000, 1'b0);
        check("add_ovf_val", 32'(last_wval), 32'h80);
        check("add_ovf_flags", 32'({z_flag, s_flag, c_flag, v_flag}), 32'b0101);
        load(2, 8'h03, 8'h80);
        run_op(3'b110, 1'b0);
        check("sra_val", 32'(last_wval), 32'hF0);
        load(2, 8'h04, 8'h04);
        run_op(3'b111, 1'b0);
        check("cmp_flags", 32'({z_flag, s_flag, c_flag, v_flag}), 32'b1000);
        load(1, 8'h00, 8'h12);
        run_op(3'b000, 1'b0);
        check("restore_val", 32'(last_wval), 32'h12);
        load(0, 8'h00, 8'h00);
        run_op(3'b000, 1'b1);
        force_full = 1'b1;
        load(2, 8'h01, 8'h02);
        run_op(3'b000, 1'b0);
        force_full = 1'b0;
        upd_pins();

        reset_mid_op();
        load(2, 8'h20, 8'h22);
        run_op(3'b000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int n;
            if ($urandom_range(0, 5) == 0) n = $urandom_range(0, 1);
            else n = $urandom_range(2, 4);
            force_full = (n >= 2) && ($urandom_range(0, 7) == 0);
            load_rand(n);
            run_op(3'($urandom), 1'($urandom_range(0, 1)));
            force_full = 1'b0;
            upd_pins();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
